antirebote_multicanal: RTL and testbench

Parametrised multi-channel button debouncer, the successor to the single-input time-based antirebote. Each of N_CANALES independent channels has its own synchroniser and stable-time validator. A channel produces a clean level plus one-cycle press and release pulses. With long-press detection compiled in, it also produces a one-cycle long-press pulse. The block sits between the raw sensor/button pins and the parking-counter control logic, replacing one antirebote instance per input.

---
 rtl/antirebote_pkg.sv | 20 ++
 rtl/antirebote_canal.sv | 146 ++++++++++++++
 rtl/antirebote_multicanal.sv | 36 +++
 tb/tb_antirebote_multicanal.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/antirebote_pkg.sv
// Shared definitions for the multi-channel debouncer: FSM state encoding,
// default 12 MHz tick constants and the counter sizing helper.
package antirebote_pkg;

  typedef enum logic [1:0] {
    SOLTADO    = 2'd0,
    VAL_PRES   = 2'd1,
    PRESIONADO = 2'd2,
    VAL_SOLT   = 2'd3
  } fsm_t;

  localparam int DEBOUNCE_TICKS_12M = 240_000;     // 20 ms at 12 MHz
  localparam int LARGO_TICKS_12M    = 12_000_000;  // 1 s at 12 MHz

  // Largest value the per-channel counter must hold.
  function automatic int cnt_max(input int deb, input int largo, input bit largo_en);
    return (largo_en && (largo > deb)) ? largo : deb;
  endfunction

endpackage

// File: rtl/antirebote_canal.sv
// One debounced channel: 2-flop synchroniser, polarity normalisation and the
// stable-time validation FSM. Long-press pulse present only with LONG_PRESS_EN.
module antirebote_canal
  import antirebote_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_12M,
  parameter int LARGO_TICKS    = LARGO_TICKS_12M,
  parameter int ACTIVO_BAJO    = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic entrada,
  output logic estado,
  output logic pulso_pres,
  output logic pulso_solt,
  output logic pulso_largo
);

`ifdef LONG_PRESS_EN
  localparam bit LARGO_EN = 1'b1;
`else
  localparam bit LARGO_EN = 1'b0;
`endif

  localparam int                CNT_W      = $clog2(cnt_max(DEBOUNCE_TICKS, LARGO_TICKS, LARGO_EN) + 1);
  localparam logic [CNT_W-1:0]  DEB_FIN    = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic              NIVEL_SOLT = (ACTIVO_BAJO != 0);

  logic [1:0]       sinc_q;
  logic             s;
  fsm_t             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             estado_d, pres_d, solt_d;

  // Synchroniser resets to the released level so leaving reset never looks like a press.
  // NOTE: every clocked register uses non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) sinc_q <= {2{NIVEL_SOLT}};
    else     sinc_q <= {sinc_q[0], entrada};
  end

  assign s = sinc_q[1] ^ NIVEL_SOLT;

`ifdef LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LARGO_FIN = CNT_W'(LARGO_TICKS - 1);
  localparam logic [CNT_W-1:0] LARGO_SAT = CNT_W'(LARGO_TICKS);
  logic largo_d, hecho_q, hecho_d;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    estado_d = estado;
    pres_d   = 1'b0;
    solt_d   = 1'b0;
`ifdef LONG_PRESS_EN
    largo_d  = 1'b0;
    hecho_d  = hecho_q;
`endif
    unique case (state_q)
      SOLTADO: begin
        if (s) begin
          state_d = VAL_PRES;
          cnt_d   = '0;
        end
      end
      VAL_PRES: begin
        if (!s) begin
          state_d = SOLTADO;
          cnt_d   = '0;
        end else if (cnt_q == DEB_FIN) begin
          state_d  = PRESIONADO;
          estado_d = 1'b1;
          pres_d   = 1'b1;
          cnt_d    = '0;
`ifdef LONG_PRESS_EN
          hecho_d  = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESIONADO: begin
        if (!s) begin
          state_d = VAL_SOLT;
          cnt_d   = '0;
        end
`ifdef LONG_PRESS_EN
        // Saturating hold count; a bounce back from VAL_SOLT restarts it but hecho blocks a repeat.
        else if (cnt_q == LARGO_FIN) begin
          cnt_d   = LARGO_SAT;
          largo_d = !hecho_q;
          hecho_d = 1'b1;
        end else if (cnt_q != LARGO_SAT) begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      VAL_SOLT: begin
        if (s) begin
          state_d = PRESIONADO;
          cnt_d   = '0;
        end else if (cnt_q == DEB_FIN) begin
          state_d  = SOLTADO;
          estado_d = 1'b0;
          solt_d   = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SOLTADO;
      cnt_q      <= '0;
      estado     <= 1'b0;
      pulso_pres <= 1'b0;
      pulso_solt <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      estado     <= estado_d;
      pulso_pres <= pres_d;
      pulso_solt <= solt_d;
    end
  end

`ifdef LONG_PRESS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pulso_largo <= 1'b0;
      hecho_q     <= 1'b0;
    end else begin
      pulso_largo <= largo_d;
      hecho_q     <= hecho_d;
    end
  end
`else
  assign pulso_largo = 1'b0;
`endif

endmodule

// File: rtl/antirebote_multicanal.sv
// N_CANALES independent debouncers side by side. Define LONG_PRESS_EN to
// build in long-press detection; otherwise pulso_largo is constant 0.
module antirebote_multicanal
  import antirebote_pkg::*;
#(
  parameter int N_CANALES      = 4,
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_12M,
  parameter int LARGO_TICKS    = LARGO_TICKS_12M,
  parameter int ACTIVO_BAJO    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CANALES-1:0] entrada,
  output logic [N_CANALES-1:0] estado,
  output logic [N_CANALES-1:0] pulso_pres,
  output logic [N_CANALES-1:0] pulso_solt,
  output logic [N_CANALES-1:0] pulso_largo
);

  for (genvar i = 0; i < N_CANALES; i++) begin : g_canal
    antirebote_canal #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .LARGO_TICKS    (LARGO_TICKS),
      .ACTIVO_BAJO    (ACTIVO_BAJO)
    ) u_canal (
      .clk         (clk),
      .rst         (rst),
      .entrada     (entrada[i]),
      .estado      (estado[i]),
      .pulso_pres  (pulso_pres[i]),
      .pulso_solt  (pulso_solt[i]),
      .pulso_largo (pulso_largo[i])
    );
  end

endmodule

// File: tb/tb_antirebote_multicanal.sv
// Bench for antirebote_multicanal: directed scenarios plus random bouncing pins,
// every cycle compared against a run-length reference model of the debouncer.
module tb_antirebote_multicanal;

  localparam int N  = 2;
  localparam int D  = 4;
  localparam int L  = 10;
  localparam int AB = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] entrada;
  logic [N-1:0] estado, pulso_pres, pulso_solt, pulso_largo;

  int n_vec  = 0;
  int n_bad  = 0;
  int edge_n = 0;

  antirebote_multicanal #(
    .N_CANALES      (N),
    .DEBOUNCE_TICKS (D),
    .LARGO_TICKS    (L),
    .ACTIVO_BAJO    (AB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .entrada     (entrada),
    .estado      (estado),
    .pulso_pres  (pulso_pres),
    .pulso_solt  (pulso_solt),
    .pulso_largo (pulso_largo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, edge_n, got, exp);
    end
  endtask

  // Reference model: a level toggles once the observed sample (pin from two
  // edges back) has disagreed with it for D+1 consecutive edges.
  bit           lvl[N];
  bit           h1[N];
  bit           h2[N];
  bit           issued[N];
  int           run[N];
  int           hold[N];
  logic [N-1:0] m_estado, m_pres, m_solt, m_largo;

  task automatic model_edge(input bit r, input logic [N-1:0] pin);
    bit s;
    bit toggled;
    m_pres  = '0;
    m_solt  = '0;
    m_largo = '0;
    for (int c = 0; c < N; c++) begin
      if (r) begin
        lvl[c] = 0; h1[c] = 0; h2[c] = 0; issued[c] = 0; run[c] = 0; hold[c] = -1;
      end else begin
        s       = h2[c];
        h2[c]   = h1[c];
        h1[c]   = pin[c] ^ (AB != 0);
        toggled = 0;
        if (s != lvl[c]) begin
          run[c]++;
          if (run[c] == D + 1) begin
            lvl[c]  = s;
            run[c]  = 0;
            toggled = 1;
            if (s) begin
              m_pres[c] = 1'b1; hold[c] = 0; issued[c] = 0;
            end else begin
              m_solt[c] = 1'b1;
            end
          end
        end else begin
          run[c] = 0;
        end
        if (lvl[c] && !toggled) begin
          hold[c] = s ? hold[c] + 1 : -1;
          if (hold[c] == L && !issued[c]) begin
            m_largo[c] = 1'b1;
            issued[c]  = 1;
          end
        end
      end
      m_estado[c] = lvl[c];
    end
  endtask

  task automatic step(input bit r, input logic [N-1:0] pin);
    logic [N-1:0] exp_largo;
    rst     = r;
    entrada = pin;
    @(posedge clk);
    edge_n++;
    model_edge(r, pin);
`ifdef LONG_PRESS_EN
    exp_largo = m_largo;
`else
    exp_largo = '0;
`endif
    #1;
    check("estado",      32'(estado),      32'(m_estado));
    check("pulso_pres",  32'(pulso_pres),  32'(m_pres));
    check("pulso_solt",  32'(pulso_solt),  32'(m_solt));
    check("pulso_largo", 32'(pulso_largo), 32'(exp_largo));
  endtask

  int e0, e_hit, e_l, n_cnt;
  int t3_len[4] = '{3, 1, 2, 8};
  int seg_left[N];
  logic [N-1:0] rnd_pin;

  initial begin
    rst     = 1'b1;
    entrada = '1;

    // 1: reset with pins released, then idle
    for (int i = 0; i < 3; i++) step(1'b1, 2'b11);
    check("t1_reset_outputs", 32'({estado, pulso_pres, pulso_solt, pulso_largo}), 32'd0);
    n_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 2'b11);
      if ((pulso_pres | pulso_solt | pulso_largo | estado) != '0) n_cnt++;
    end
    check("t1_idle_silent", 32'(n_cnt), 32'd0);

    // 2: clean press on ch0
    e0 = edge_n + 1; e_hit = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 2'b10);
      if (pulso_pres[0] && e_hit < 0) e_hit = edge_n;
    end
    check("t2_press_latency", 32'(e_hit - e0), 32'(D + 2));
    check("t2_estado_held", 32'(estado), 32'b01);
    for (int i = 0; i < 12; i++) step(1'b0, 2'b11);

    // 3: bounce on ch0 must be rejected
    n_cnt = 0;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < t3_len[k]; i++) begin
        step(1'b0, (k % 2 == 0) ? 2'b10 : 2'b11);
        if (pulso_pres[0] || estado[0]) n_cnt++;
      end
    check("t3_bounce_rejected", 32'(n_cnt), 32'd0);
    e0 = edge_n + 1; e_hit = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 2'b10);
      if (pulso_pres[0] && e_hit < 0) e_hit = edge_n;
    end
    check("t3_press_latency", 32'(e_hit - e0), 32'(D + 2));
    for (int i = 0; i < 12; i++) step(1'b0, 2'b11);

    // 4: both channels together
    n_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 2'b00);
      if (pulso_pres == 2'b11) n_cnt++;
    end
    check("t4_joint_press", 32'(n_cnt), 32'd1);
    n_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 2'b11);
      if (pulso_solt == 2'b11) n_cnt++;
    end
    check("t4_joint_release", 32'(n_cnt), 32'd1);

    // 5: long hold on ch1
    e_hit = -1; e_l = -1; n_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 2'b01);
      if (pulso_pres[1] && e_hit < 0) e_hit = edge_n;
      if (pulso_largo[1]) begin
        n_cnt++;
        if (e_l < 0) e_l = edge_n;
      end
    end
`ifdef LONG_PRESS_EN
    check("t5_long_count", 32'(n_cnt), 32'd1);
    check("t5_long_delay", 32'(e_l - e_hit), 32'(L));
`else
    check("t5_long_absent", 32'(n_cnt), 32'd0);
`endif
    for (int i = 0; i < 12; i++) step(1'b0, 2'b11);

    // 6: reset in the middle of press validation
    for (int i = 0; i < 5; i++) step(1'b0, 2'b10);
    step(1'b1, 2'b10);
    check("t6_reset_quiet", 32'({estado, pulso_pres}), 32'd0);
    e0 = edge_n + 1; e_hit = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 2'b10);
      if (pulso_pres[0] && e_hit < 0) e_hit = edge_n;
    end
    check("t6_press_after_reset", 32'(e_hit - e0), 32'(D + 2));
    for (int i = 0; i < 12; i++) step(1'b0, 2'b11);

    // Random bouncing segments with occasional resets
    rnd_pin = '1;
    for (int c = 0; c < N; c++) seg_left[c] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++) begin
        if (seg_left[c] == 0) begin
          rnd_pin[c]  = 1'($urandom_range(0, 1));
          seg_left[c] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 3))
                                                    : int'($urandom_range(4, 25));
        end
        seg_left[c]--;
      end
      step($urandom_range(0, 399) == 0, rnd_pin);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
